// File: rtl/dm_bus_ctrl.sv
// dm_bus_ctrl: data-memory access controller for the EX/DM stage.
// Runs the EX_DM load/store on the shared multicore bus with a
// request/grant/ack handshake, stalls the pipeline while the access is in
// flight and returns load data to the write-back mux.
// Optional feature: define DM_TIMEOUT_EN to abort transactions that get no
// ack within TIMEOUT cycles (sets sticky dm_err, loads return 16'hDEAD).
module dm_bus_ctrl #(
    parameter int CORE_ID = 0,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dm_re_EX_DM,
    input  logic        dm_we_EX_DM,
    input  logic [15:0] dst_EX_DM,
    input  logic [15:0] p1_EX_DM,
    input  logic        stall_DM_WB,
    output logic        stall_dm,
    output logic [15:0] dm_rd_data_EX_DM,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    output logic [1:0]  bus_id,
    input  logic [15:0] bus_rdata,
    input  logic        bus_ack,
    output logic        dm_err
);

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    state_t state;
    logic   req_any;

    assign req_any = dm_re_EX_DM | dm_we_EX_DM;
    assign bus_id  = 2'(CORE_ID);

    // Hold the front of the pipe from the moment a request shows up in IDLE
    // until the bus transfer completes; DONE lets the instruction advance.
    always_comb begin
        stall_dm = 1'b0;
        if ((state == IDLE && req_any) || state == REQ || state == XFER)
            stall_dm = 1'b1;
    end

`ifdef DM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;
    logic             err_q;

    assign dm_err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT == 0);
    assign dm_err         = 1'b0;
`endif

    // Bus handshake FSM; all bus outputs and the load data are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            bus_req          <= 1'b0;
            bus_we           <= 1'b0;
            bus_addr         <= 16'h0000;
            bus_wdata        <= 16'h0000;
            dm_rd_data_EX_DM <= 16'h0000;
`ifdef DM_TIMEOUT_EN
            cnt              <= '0;
            err_q            <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        bus_addr  <= dst_EX_DM;
                        bus_wdata <= p1_EX_DM;
                        bus_we    <= dm_we_EX_DM;
                        bus_req   <= 1'b1;
                        state     <= REQ;
`ifdef DM_TIMEOUT_EN
                        cnt       <= '0;
`endif
                    end
                end
                REQ: begin
                    if (bus_gnt && bus_ack) begin
                        if (!bus_we)
                            dm_rd_data_EX_DM <= bus_rdata;
                        bus_req <= 1'b0;
                        state   <= DONE;
                    end else begin
`ifdef DM_TIMEOUT_EN
                        if (cnt == CNT_LAST) begin
                            if (!bus_we)
                                dm_rd_data_EX_DM <= 16'hDEAD;
                            err_q   <= 1'b1;
                            bus_req <= 1'b0;
                            state   <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (bus_gnt)
                                state <= XFER;
                        end
`else
                        if (bus_gnt)
                            state <= XFER;
`endif
                    end
                end
                XFER: begin
                    if (bus_ack) begin
                        if (!bus_we)
                            dm_rd_data_EX_DM <= bus_rdata;
                        bus_req <= 1'b0;
                        state   <= DONE;
                    end else begin
`ifdef DM_TIMEOUT_EN
                        if (cnt == CNT_LAST) begin
                            if (!bus_we)
                                dm_rd_data_EX_DM <= 16'hDEAD;
                            err_q   <= 1'b1;
                            bus_req <= 1'b0;
                            state   <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
`endif
                    end
                end
                DONE: begin
                    if (!stall_DM_WB)
                        state <= IDLE;
                end
                default: begin
                    bus_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
